// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   staging_q, staging_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    cur_digit;
  logic [3:0]    lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == 2'd3);

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    staging_d    = staging_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    // A load landing on the boundary goes straight to the shadow so it is
    // never left stranded in staging for a whole extra frame.
    if (boundary) begin
      if (load) begin
        shadow_d     = digits_in;
        pending_d    = 1'b0;
        frame_done_d = 1'b1;
      end else if (pending_q) begin
        shadow_d     = staging_q;
        pending_d    = 1'b0;
        frame_done_d = 1'b1;
      end
    end else if (load) begin
      staging_d = digits_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_digit = shadow_q[3:0];
      2'd1:    cur_digit = shadow_q[7:4];
      2'd2:    cur_digit = shadow_q[11:8];
      default: cur_digit = shadow_q[15:12];
    endcase
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (shadow_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (shadow_q[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (shadow_q[7:4] == 4'd0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  // Blanked digits still light their anode; only the guard and digit_en darken a slot.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if ((cnt_q >= GUARD_C) && digit_en[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lz_blank[idx_q] ? 7'b1111111 : decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      staging_q    <= 16'h0000;
      shadow_q     <= 16'h0000;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
